// File: rtl/param_single_port_ram.sv
// Parametrised synchronous single-port RAM with byte-lane write enables,
// selectable read-during-write behaviour, optional output register and post-reset clear.
module param_single_port_ram #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 6,
  parameter int BYTE_WIDTH     = 8,
  parameter int WRITE_MODE     = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             rvalid,
  output logic                             busy
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    clr_we;
  logic                    acc;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   old_word;
  logic [DATA_WIDTH-1:0]   merged_word;

  logic [DATA_WIDTH-1:0]   rd1_q, rd1_d;
  logic                    v1_q, v1_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == CLR_LAST) state_d = ST_RUN;
    end
  end

  // Outputs of the sequencer; rst gates everything because it is synchronous.
  always_comb begin
    busy   = rst ? (CLEAR_ON_RESET != 0) : (state_q == ST_CLEAR);
    clr_we = !rst && (state_q == ST_CLEAR);
    acc    = !rst && (state_q == ST_RUN) && en;
  end

  assign old_word = mem_q[addr];

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (acc && we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem_q[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Stage 1: result of the access edge; NO_CHANGE writes leave it untouched.
  always_comb begin
    rd1_d = rd1_q;
    v1_d  = 1'b0;
    if (acc) begin
      if (!we) begin
        rd1_d = old_word;
        v1_d  = 1'b1;
      end else if (WRITE_MODE == 0) begin
        rd1_d = old_word;
        v1_d  = 1'b1;
      end else if (WRITE_MODE == 1) begin
        rd1_d = merged_word;
        v1_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_q <= '0;
      v1_q  <= 1'b0;
    end else begin
      rd1_q <= rd1_d;
      v1_q  <= v1_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] rd2_q;
      logic                  v2_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd2_q <= '0;
          v2_q  <= 1'b0;
        end else begin
          if (v1_q) rd2_q <= rd1_q;
          v2_q <= v1_q;
        end
      end

      assign rdata  = rd2_q;
      assign rvalid = v2_q;
    end else begin : g_no_out_reg
      assign rdata  = rd1_q;
      assign rvalid = v1_q;
    end
  endgenerate

endmodule
